lsu_align: RTL and testbench

Load/store alignment unit between the EX/MEM pipeline register and the word-organised data memory. Accepts one load or store request at a time over a valid/ready handshake and converts byte address plus funct3 into a word-aligned address, per-lane byte enables and lane-shifted write data. Collects the memory's one-cycle-latency read word and returns a sign- or zero-extended result. Flags misaligned or unsupported accesses without touching memory.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_load_extract.sv | 28 ++
 rtl/lsu_align.sv | 120 ++++++++++++
 tb/tb_lsu_align.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store alignment unit.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, LWAIT, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] be_of(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: be_of = 4'b0001 << off;
      F3_H, F3_HU: be_of = 4'b0011 << off;
      F3_W:        be_of = 4'b1111;
      default:     be_of = '0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_H, F3_HU: misaligned = off[0];
      F3_W:        misaligned = (off != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

  // Unsigned sub-word forms only exist for loads.
  function automatic logic illegal(input logic [2:0] funct3, input logic we);
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = we;
      default:          illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational lane select and sign/zero extension of a memory read word.
module lsu_load_extract
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] ext
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    ext     = '0;
    case (funct3)
      F3_B:  ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F3_BU: ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_H:  ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      F3_HU: ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      F3_W:  ext = shifted;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: one request at a time between EX/MEM and a
// word-organised data memory with one-cycle read latency.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  state_t            state;
  logic              we_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [1:0]        req_off;
  logic              req_bad;
  logic [DATA_W-1:0] load_ext;

  assign req_off   = req_addr[1:0];
  assign req_bad   = illegal(req_funct3, req_we) || misaligned(req_funct3, req_off);
  assign req_ready = (state == IDLE);

  lsu_load_extract #(.DATA_W(DATA_W)) u_extract (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .ext    (load_ext)
  );

  // Memory strobes are computed at the accept edge so they are registered
  // outputs during the single ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      off_q     <= '0;
      f3_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            off_q <= req_off;
            f3_q  <= req_funct3;
            if (req_bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= ACCESS;
              mem_addr  <= {req_addr[DM_ADDRESS-1:2], 2'b00};
              mem_we    <= req_we;
              mem_re    <= !req_we;
              mem_be    <= req_we ? be_of(req_funct3, req_off) : 4'b0000;
              mem_wdata <= req_we ? (req_wdata << {req_off, 3'b000}) : '0;
            end
          end
        end
        ACCESS: begin
          mem_addr  <= '0;
          mem_re    <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= '0;
          mem_wdata <= '0;
          if (we_q) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            state <= LWAIT;
          end
        end
        LWAIT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= load_ext;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align with a behavioural data memory and a
// response scoreboard.
module tb_lsu_align;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [8:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_align #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:127];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr[8:2]];
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr[8:2]][8*i +: 8] = mem_wdata[8*i +: 8];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Presents one request starting at posedge+1; returns #1 after the accept edge.
  task automatic issue(input logic we, input logic [8:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, output int acc);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    acc        = cyc;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    req_wdata  = '0;
  endtask

  // Waits (bounded) for rsp_valid, recording memory activity seen on the way.
  task automatic wait_rsp(output int lat, output int n_re, output int n_we,
                          output logic [8:0] a, output logic [3:0] be, output logic [31:0] wd);
    lat = 0; n_re = 0; n_we = 0; a = '0; be = '0; wd = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_re) begin n_re++; a = mem_addr; end
      if (mem_we) begin n_we++; a = mem_addr; be = mem_be; wd = mem_wdata; end
      if (rsp_valid) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({mem_re, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem got re=%b we=%b be=%b addr=%h wd=%h exp all 0",
               mem_re, mem_we, mem_be, mem_addr, mem_wdata);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_rsp got v=%b e=%b d=%h exp 0", rsp_valid, rsp_err, rsp_rdata);
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_store();
    logic [8:0]  v_addr [4] = '{9'h013, 9'h01A, 9'h01C, 9'h031};
    logic [2:0]  v_f3   [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
    logic [31:0] v_wd   [4] = '{32'h000000A5, 32'h0000BEEF, 32'hDEADBEEF, 32'h12345678};
    logic [8:0]  v_ma   [4] = '{9'h010, 9'h018, 9'h01C, 9'h030};
    logic [3:0]  v_be   [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0010};
    logic [31:0] v_mwd  [4] = '{32'hA5000000, 32'hBEEF0000, 32'hDEADBEEF, 32'h34567800};
    logic [31:0] v_pre  [4] = '{32'h11223344, 32'h55667788, 32'h00000000, 32'hAAAAAAAA};
    logic [31:0] v_post [4] = '{32'hA5223344, 32'hBEEF7788, 32'hDEADBEEF, 32'hAAAA78AA};
    int acc, lat, nre, nwe;
    logic [8:0] a; logic [3:0] be; logic [31:0] wd;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      mem[v_ma[k][8:2]] = v_pre[k];
      checks++;
      if (req_ready !== 1'b1) begin
        errors++; $display("FAIL st_ready[%0d] got %b exp 1", k, req_ready);
      end
      sbq.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
      issue(1'b1, v_addr[k], v_f3[k], v_wd[k], acc);
      wait_rsp(lat, nre, nwe, a, be, wd);
      e = sbq.pop_front();
      checks++;
      if (lat !== e.lat || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
        errors++;
        $display("FAIL st_rsp[%0d] got lat=%0d err=%b d=%h exp lat=%0d err=%b d=%h",
                 k, lat, rsp_err, rsp_rdata, e.lat, e.err, e.rdata);
      end
      checks++;
      if (nre !== 0 || nwe !== 1 || a !== v_ma[k] || be !== v_be[k] || wd !== v_mwd[k]) begin
        errors++;
        $display("FAIL st_bus[%0d] got re=%0d we=%0d addr=%h be=%b wd=%h exp 0 1 %h %b %h",
                 k, nre, nwe, a, be, wd, v_ma[k], v_be[k], v_mwd[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem[v_ma[k][8:2]] !== v_post[k]) begin
        errors++;
        $display("FAIL st_done[%0d] got v=%b rdy=%b mem=%h exp 0 1 %h",
                 k, rsp_valid, req_ready, mem[v_ma[k][8:2]], v_post[k]);
      end
    end
  endtask

  task automatic test_load();
    logic [8:0]  v_addr [7] = '{9'h022, 9'h022, 9'h001, 9'h003, 9'h042, 9'h044, 9'h040};
    logic [2:0]  v_f3   [7] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b000, 3'b010, 3'b001};
    logic [31:0] v_word [7] = '{32'h80F01234, 32'h80F01234, 32'h00007F00, 32'hC0000000,
                                32'h00800000, 32'h89ABCDEF, 32'h12347FFF};
    logic [31:0] v_exp  [7] = '{32'hFFFF80F0, 32'h000080F0, 32'h0000007F, 32'h000000C0,
                                32'hFFFFFF80, 32'h89ABCDEF, 32'h00007FFF};
    int acc, lat, nre, nwe;
    logic [8:0] a; logic [3:0] be; logic [31:0] wd;
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      mem[v_addr[k][8:2]] = v_word[k];
      sbq.push_back('{rdata: v_exp[k], err: 1'b0, lat: 3});
      issue(1'b0, v_addr[k], v_f3[k], 32'hFFFF_FFFF, acc);
      wait_rsp(lat, nre, nwe, a, be, wd);
      e = sbq.pop_front();
      checks++;
      if (lat !== e.lat || rsp_err !== e.err || rsp_rdata !== e.rdata) begin
        errors++;
        $display("FAIL ld_rsp[%0d] got lat=%0d err=%b d=%h exp lat=%0d err=%b d=%h",
                 k, lat, rsp_err, rsp_rdata, e.lat, e.err, e.rdata);
      end
      checks++;
      if (nre !== 1 || nwe !== 0 || a !== {v_addr[k][8:2], 2'b00}) begin
        errors++;
        $display("FAIL ld_bus[%0d] got re=%0d we=%0d addr=%h exp 1 0 %h",
                 k, nre, nwe, a, {v_addr[k][8:2], 2'b00});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_errors();
    logic       v_we   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0] v_addr [6] = '{9'h006, 9'h000, 9'h010, 9'h001, 9'h003, 9'h008};
    logic [2:0] v_f3   [6] = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b101, 3'b110};
    int acc, lat, nre, nwe;
    logic [8:0] a; logic [3:0] be; logic [31:0] wd;
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      sbq.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
      issue(v_we[k], v_addr[k], v_f3[k], 32'h5A5A5A5A, acc);
      wait_rsp(lat, nre, nwe, a, be, wd);
      e = sbq.pop_front();
      checks++;
      if (lat !== e.lat || rsp_err !== e.err || rsp_rdata !== e.rdata || nre !== 0 || nwe !== 0) begin
        errors++;
        $display("FAIL err_rsp[%0d] got lat=%0d err=%b d=%h re=%0d we=%0d exp lat=%0d err=%b d=%h 0 0",
                 k, lat, rsp_err, rsp_rdata, nre, nwe, e.lat, e.err, e.rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int acc, lat, nre, nwe, bad;
    logic [8:0] a; logic [3:0] be; logic [31:0] wd;
    exp_t e;
    mem[16] = 32'hCAFEF00D;
    rsp_ready = 1'b0;
    sbq.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, lat: 3});
    issue(1'b0, 9'h040, 3'b010, 32'h0, acc);
    wait_rsp(lat, nre, nwe, a, be, wd);
    e = sbq.pop_front();
    checks++;
    if (lat !== e.lat || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++;
      $display("FAIL bp_rsp got lat=%0d d=%h err=%b exp lat=%0d d=%h err=%b",
               lat, rsp_rdata, rsp_err, e.lat, e.rdata, e.err);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== 1'b0 ||
          req_ready !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles exp 0", bad);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got v=%b rdy=%b exp 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int acc, lat, nre, nwe, bad;
    logic [8:0] a; logic [3:0] be; logic [31:0] wd;
    exp_t e;
    mem[20] = 32'h01020304;
    issue(1'b1, 9'h050, 3'b010, 32'hFFFFFFFF, acc);
    checks++;
    if (mem_we !== 1'b1) begin
      errors++; $display("FAIL rm_access got we=%b exp 1", mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_be !== 4'b0000) begin
      errors++; $display("FAIL rm_async got we=%b be=%b exp 0 0000", mem_we, mem_be);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_we !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || mem[20] !== 32'h01020304) begin
      errors++;
      $display("FAIL rm_discard got bad=%0d mem=%h exp 0 01020304", bad, mem[20]);
    end
    @(posedge clk); #1;
    sbq.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
    issue(1'b1, 9'h050, 3'b010, 32'hFFFFFFFF, acc);
    wait_rsp(lat, nre, nwe, a, be, wd);
    e = sbq.pop_front();
    @(posedge clk); #1;
    checks++;
    if (lat !== e.lat || nwe !== 1 || mem[20] !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL rm_next got lat=%0d we=%0d mem=%h exp %0d 1 ffffffff", lat, nwe, mem[20], e.lat);
    end
  endtask

  task automatic test_back_to_back();
    int acc, prev_acc, prev_gap, lat, nre, nwe;
    logic [8:0] a; logic [3:0] be; logic [31:0] wd;
    logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] word;
    logic [6:0]  widx;
    logic [2:0]  f3;
    logic [1:0]  off;
    exp_t e;
    prev_acc = -1;
    prev_gap = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        word = $urandom;
        widx = 7'($urandom_range(64, 127));
        sbq.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
        issue(1'b1, {widx, 2'b00}, 3'b010, word, acc);
      end else begin
        f3  = f3s[$urandom_range(0, 4)];
        off = 2'($urandom_range(0, 3));
        if (f3 == 3'b010) off = 2'b00;
        else if (f3 != 3'b000 && f3 != 3'b100) off[0] = 1'b0;
        sbq.push_back('{rdata: ref_load(f3, off, word), err: 1'b0, lat: 3});
        issue(1'b0, {widx, off}, f3, 32'h0, acc);
      end
      if (prev_acc >= 0) begin
        checks++;
        if (acc - prev_acc !== prev_gap) begin
          errors++;
          $display("FAIL b2b_gap[%0d] got %0d exp %0d", i, acc - prev_acc, prev_gap);
        end
      end
      wait_rsp(lat, nre, nwe, a, be, wd);
      e = sbq.pop_front();
      checks++;
      if (lat !== e.lat || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++;
        $display("FAIL b2b_rsp[%0d] got lat=%0d d=%h err=%b exp lat=%0d d=%h err=%b",
                 i, lat, rsp_rdata, rsp_err, e.lat, e.rdata, e.err);
      end
      prev_acc = acc;
      prev_gap = (i % 2 == 0) ? 3 : 4;
      @(posedge clk); #1;
    end
    checks++;
    if (sbq.size() !== 0) begin
      errors++; $display("FAIL sb_empty got %0d exp 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
